// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_CPU  = 1'b0,
    REQ_HOST = 1'b1
  } req_id_e;

  localparam int DEF_ADDR_W     = 64;
  localparam int DEF_DATA_W     = 64;
  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_MAX = 4;

  // Bits needed to hold any value in 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    if (max_val < 2) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of CPU grants that were given while the host was waiting.
// When it reaches STARVE_MAX the host is forced to win the next arbitration.
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic host_force_o
);

  localparam int               CNT_W   = cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over increment; increment stops once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign host_force_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mux2to1.sv
// Generic two-input multiplexer of configurable width.
module mux2to1 #(
  parameter int WIDTH = 1
) (
  input  logic             sel_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises CPU and host accesses onto the single-port data memory.
// Each access latches a command, holds it on the memory for MEM_LAT cycles,
// then pulses the acknowledge of whoever issued it for one cycle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_stall,

  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,

  output logic [DATA_W-1:0] rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CMD_W    = 1 + ADDR_W + DATA_W;
  localparam int               LAT_W    = cnt_width(MEM_LAT - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

  arb_state_e        state_q;
  req_id_e           id_q;
  logic              cmd_we_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  logic [LAT_W-1:0]  lat_cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_en_q;
  logic              cpu_ack_q;
  logic              host_ack_q;

  logic              is_idle;
  logic              host_force;
  logic              host_wins;
  logic              grant;
  logic              starve_inc;
  logic              starve_clr;

  logic [CMD_W-1:0]  cmd_d;
  logic              cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_d;

  // Arbitration: the CPU normally wins; the host wins when it is alone or
  // when it has been passed over STARVE_MAX times in a row.
  assign is_idle   = (state_q == ARB_IDLE);
  assign host_wins = host_req & (host_force | ~cpu_req);
  assign grant     = is_idle & (cpu_req | host_req);

  // A CPU grant over a waiting host counts toward starvation; serving the
  // host, or an idle cycle with no host demand, forgets the history.
  assign starve_inc = grant & ~host_wins & host_req;
  assign starve_clr = (grant & host_wins) | (is_idle & ~host_req);

  dmem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (starve_clr),
    .inc_i        (starve_inc),
    .host_force_o (host_force)
  );

  mux2to1 #(
    .WIDTH (CMD_W)
  ) u_cmd_mux (
    .sel_i (host_wins),
    .d0_i  ({cpu_we, cpu_addr, cpu_wdata}),
    .d1_i  ({host_we, host_addr, host_wdata}),
    .y_o   (cmd_d)
  );

  assign {cmd_we_d, cmd_addr_d, cmd_wdata_d} = cmd_d;

  // Access sequencer: latch the winner, hold it on the memory, then respond.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      id_q        <= REQ_CPU;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      lat_cnt_q   <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      host_ack_q  <= 1'b0;
    end else begin
      cpu_ack_q  <= 1'b0;
      host_ack_q <= 1'b0;
      unique case (state_q)
        ARB_IDLE: begin
          if (grant) begin
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            id_q        <= host_wins ? REQ_HOST : REQ_CPU;
            lat_cnt_q   <= LAT_LOAD;
            mem_en_q    <= 1'b1;
            state_q     <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (lat_cnt_q == '0) begin
            mem_en_q <= 1'b0;
            if (!cmd_we_q) begin
              rdata_q <= mem_rdata;
            end
            cpu_ack_q  <= (id_q == REQ_CPU);
            host_ack_q <= (id_q == REQ_HOST);
            state_q    <= ARB_RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end
        end
        ARB_RESP: begin
          state_q <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_en_q & cmd_we_q;
  assign mem_addr  = cmd_addr_q;
  assign mem_wdata = cmd_wdata_q;
  assign rdata     = rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign host_ack  = host_ack_q;

  // The pipeline freezes until its access is acknowledged, never during reset.
  assign cpu_stall = cpu_req & ~cpu_ack_q & ~reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level schedule of expected outputs
// for the main instance, plus a second instance built with a one-cycle
// memory latency.
module tb_dmem_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 2;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;

  // Main instance signals
  logic        cpuReqA, cpuWeA, cpuAckA, cpuStallA;
  logic [63:0] cpuAddrA, cpuWdataA;
  logic        hostReqA, hostWeA, hostAckA;
  logic [63:0] hostAddrA, hostWdataA;
  logic [63:0] rdataA;
  logic        memEnA, memWeA;
  logic [63:0] memAddrA, memWdataA, memRdataA;

  // Single-cycle-latency instance signals
  logic        cpuReqB, cpuAckB, cpuStallB, hostAckB, memEnB, memWeB;
  logic [63:0] rdataB, memAddrB, memWdataB, memRdataB;

  logic [63:0] memA [256];
  logic [63:0] memB [256];
  logic [63:0] modelMem [256];

  typedef struct {
    bit          en;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    bit          cpuAck;
    bit          hostAck;
    bit          rdUpd;
    logic [63:0] rdVal;
  } slot_t;

  slot_t       sched [int];
  slot_t       cur;
  slot_t       tmp;
  logic [63:0] expRdata = '0;
  int          freeAt = 0;
  int          starve = 0;
  bit          modelOn = 1'b0;
  bit          hostWins;

  int          cpuAckCyc [$];
  int          hostAckCyc [$];
  int          ackOrder [$];
  logic [63:0] ackRdata [$];

  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  // Cycle numbering: cycle n starts at the n-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(
    .ADDR_W (64), .DATA_W (64), .MEM_LAT (LAT), .STARVE_MAX (SMAX)
  ) dutA (
    .clk (clk), .reset (reset),
    .cpu_req (cpuReqA), .cpu_we (cpuWeA), .cpu_addr (cpuAddrA),
    .cpu_wdata (cpuWdataA), .cpu_ack (cpuAckA), .cpu_stall (cpuStallA),
    .host_req (hostReqA), .host_we (hostWeA), .host_addr (hostAddrA),
    .host_wdata (hostWdataA), .host_ack (hostAckA),
    .rdata (rdataA),
    .mem_en (memEnA), .mem_we (memWeA), .mem_addr (memAddrA),
    .mem_wdata (memWdataA), .mem_rdata (memRdataA)
  );

  dmem_arbiter #(
    .ADDR_W (64), .DATA_W (64), .MEM_LAT (1), .STARVE_MAX (4)
  ) dutB (
    .clk (clk), .reset (reset),
    .cpu_req (cpuReqB), .cpu_we (1'b0), .cpu_addr (64'h10),
    .cpu_wdata (64'h0), .cpu_ack (cpuAckB), .cpu_stall (cpuStallB),
    .host_req (1'b0), .host_we (1'b0), .host_addr (64'h0),
    .host_wdata (64'h0), .host_ack (hostAckB),
    .rdata (rdataB),
    .mem_en (memEnB), .mem_we (memWeB), .mem_addr (memAddrB),
    .mem_wdata (memWdataB), .mem_rdata (memRdataB)
  );

  // Memories: asynchronous read, write on the clock edge while enabled.
  assign memRdataA = memA[memAddrA[7:0]];
  assign memRdataB = memB[memAddrB[7:0]];

  always @(posedge clk) begin
    if (memEnA && memWeA) memA[memAddrA[7:0]] <= memWdataA;
    if (memEnB && memWeB) memB[memAddrB[7:0]] <= memWdataB;
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit cR, input bit cW, input logic [63:0] cA,
                               input logic [63:0] cD, input bit hR, input bit hW,
                               input logic [63:0] hA, input logic [63:0] hD);
    cpuReqA   = cR;
    cpuWeA    = cW;
    cpuAddrA  = cA;
    cpuWdataA = cD;
    hostReqA  = hR;
    hostWeA   = hW;
    hostAddrA = hA;
    hostWdataA = hD;
  endtask

  // Advance n cycles, optionally releasing a requester after its ack.
  task automatic runCycles(input int n, input bit dropCpu, input bit dropHost);
    bit sawC;
    bit sawH;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sawC = cpuAckA;
      sawH = hostAckA;
      @(posedge clk);
      #1;
      if (dropCpu && sawC) cpuReqA = 1'b0;
      if (dropHost && sawH) hostReqA = 1'b0;
    end
  endtask

  task automatic clearLogs();
    cpuAckCyc.delete();
    hostAckCyc.delete();
    ackOrder.delete();
    ackRdata.delete();
  endtask

  // Compare against the schedule, then let the model decide what the
  // inputs seen this cycle will cause in later cycles.
  always @(negedge clk) begin
    if (modelOn) begin
      cur = '{default: '0};
      if (sched.exists(cyc)) cur = sched[cyc];
      if (cur.rdUpd) expRdata = cur.rdVal;
      checkOutput("mem_en", 64'(memEnA), 64'(cur.en));
      if (cur.en) begin
        checkOutput("mem_we", 64'(memWeA), 64'(cur.we));
        checkOutput("mem_addr", memAddrA, cur.addr);
        checkOutput("mem_wdata", memWdataA, cur.wdata);
      end
      checkOutput("cpu_ack", 64'(cpuAckA), 64'(cur.cpuAck));
      checkOutput("host_ack", 64'(hostAckA), 64'(cur.hostAck));
      checkOutput("rdata", rdataA, expRdata);
      checkOutput("cpu_stall", 64'(cpuStallA),
                  64'(cpuReqA & ~cur.cpuAck & ~reset));
      if (cpuAckA) begin
        cpuAckCyc.push_back(cyc);
        ackOrder.push_back(0);
        ackRdata.push_back(rdataA);
      end
      if (hostAckA) begin
        hostAckCyc.push_back(cyc);
        ackOrder.push_back(1);
        ackRdata.push_back(rdataA);
      end
      sched.delete(cyc);

      if (reset) begin
        sched.delete();
        tmp = '{default: '0};
        tmp.rdUpd = 1'b1;
        tmp.rdVal = '0;
        sched[cyc + 1] = tmp;
        freeAt = cyc + 1;
        starve = 0;
      end else if (cyc >= freeAt) begin
        if (cpuReqA || hostReqA) begin
          hostWins = hostReqA && ((starve == SMAX) || !cpuReqA);
          if (hostWins) starve = 0;
          else if (hostReqA) starve = (starve < SMAX) ? starve + 1 : starve;
          else starve = 0;
          tmp = '{default: '0};
          tmp.en    = 1'b1;
          tmp.we    = hostWins ? hostWeA : cpuWeA;
          tmp.addr  = hostWins ? hostAddrA : cpuAddrA;
          tmp.wdata = hostWins ? hostWdataA : cpuWdataA;
          for (int k = 1; k <= LAT; k++) sched[cyc + k] = tmp;
          tmp.en      = 1'b0;
          tmp.cpuAck  = !hostWins;
          tmp.hostAck = hostWins;
          if (tmp.we) begin
            modelMem[tmp.addr[7:0]] = tmp.wdata;
          end else begin
            tmp.rdUpd = 1'b1;
            tmp.rdVal = modelMem[tmp.addr[7:0]];
          end
          sched[cyc + LAT + 1] = tmp;
          freeAt = cyc + LAT + 2;
        end else begin
          starve = 0;
        end
      end
    end
  end

  int s;
  int enCnt;
  int ackAt;
  logic [63:0] rdAt;
  int expOrder [6] = '{0, 0, 1, 0, 0, 1};

  initial begin
    for (int i = 0; i < 256; i++) begin
      memA[i]     = {32'hC0DE_0000, 24'h0, 8'(i)};
      modelMem[i] = {32'hC0DE_0000, 24'h0, 8'(i)};
      memB[i]     = '0;
    end
    memA[8'h40]     = 64'hDEAD_BEEF;
    modelMem[8'h40] = 64'hDEAD_BEEF;
    memB[8'h10]     = 64'h5555;

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    cpuReqB = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    modelOn = 1'b1;
    @(posedge clk);
    #1;
    // Reset state
    checkOutput("rst mem_en", 64'(memEnA), 64'h0);
    checkOutput("rst mem_we", 64'(memWeA), 64'h0);
    checkOutput("rst mem_addr", memAddrA, 64'h0);
    checkOutput("rst mem_wdata", memWdataA, 64'h0);
    checkOutput("rst acks", 64'({cpuAckA, hostAckA}), 64'h0);
    checkOutput("rst rdata", rdataA, 64'h0);
    reset = 1'b0;
    runCycles(1, 0, 0);

    // CPU read of 0x40
    $display("[TB] cpu read");
    clearLogs();
    s = cyc;
    applyStimulus(1, 0, 64'h40, 0, 0, 0, 0, 0);
    runCycles(6, 1, 1);
    checkOutput("s1 ack count", 64'(cpuAckCyc.size()), 64'd1);
    if (cpuAckCyc.size() >= 1) begin
      checkOutput("s1 ack cycle", 64'(cpuAckCyc[0] - s), 64'd3);
      checkOutput("s1 rdata", ackRdata[0], 64'hDEAD_BEEF);
    end

    // Host write then CPU read of the same word
    $display("[TB] host write then cpu read");
    clearLogs();
    s = cyc;
    applyStimulus(0, 0, 0, 0, 1, 1, 64'h80, 64'h1234);
    runCycles(4, 1, 1);
    applyStimulus(1, 0, 64'h80, 0, 0, 0, 0, 0);
    runCycles(5, 1, 1);
    checkOutput("s2 counts", 64'({cpuAckCyc.size(), hostAckCyc.size()}), 64'h0000_0001_0000_0001);
    if (cpuAckCyc.size() >= 1 && hostAckCyc.size() >= 1) begin
      checkOutput("s2 host ack cycle", 64'(hostAckCyc[0] - s), 64'd3);
      checkOutput("s2 cpu ack cycle", 64'(cpuAckCyc[0] - s), 64'd7);
      checkOutput("s2 rdata", ackRdata[ackRdata.size() - 1], 64'h1234);
    end

    // Simultaneous requests
    $display("[TB] simultaneous requests");
    clearLogs();
    s = cyc;
    applyStimulus(1, 0, 64'h40, 0, 1, 0, 64'h88, 0);
    runCycles(10, 1, 1);
    checkOutput("s3 counts", 64'({cpuAckCyc.size(), hostAckCyc.size()}), 64'h0000_0001_0000_0001);
    if (cpuAckCyc.size() >= 1 && hostAckCyc.size() >= 1) begin
      checkOutput("s3 cpu first", 64'(ackOrder[0]), 64'd0);
      checkOutput("s3 ack gap", 64'(hostAckCyc[0] - cpuAckCyc[0]), 64'(LAT + 2));
      checkOutput("s3 host rdata", ackRdata[1], 64'hC0DE_0000_0000_0088);
    end

    // Starvation with both requests held
    $display("[TB] starvation");
    clearLogs();
    applyStimulus(1, 0, 64'h40, 0, 1, 0, 64'h88, 0);
    runCycles(24, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("s4 grant count", 64'(ackOrder.size()), 64'd6);
    if (ackOrder.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        checkOutput($sformatf("s4 grant %0d", i), 64'(ackOrder[i]), 64'(expOrder[i]));
      end
    end
    runCycles(2, 0, 0);

    // Reset during the second access cycle
    $display("[TB] reset mid-access");
    clearLogs();
    s = cyc;
    applyStimulus(1, 0, 64'h40, 0, 0, 0, 0, 0);
    runCycles(2, 0, 0);
    reset = 1'b1;
    runCycles(1, 0, 0);
    reset = 1'b0;
    checkOutput("s5 mem_en", 64'(memEnA), 64'h0);
    checkOutput("s5 no ack", 64'({cpuAckA, hostAckA}), 64'h0);
    checkOutput("s5 rdata", rdataA, 64'h0);
    runCycles(6, 1, 1);
    checkOutput("s5 ack count", 64'(cpuAckCyc.size()), 64'd1);
    if (cpuAckCyc.size() >= 1) begin
      checkOutput("s5 ack cycle", 64'(cpuAckCyc[0] - s), 64'd6);
    end

    // Single-cycle memory latency instance
    $display("[TB] one-cycle latency build");
    s = cyc;
    enCnt = 0;
    ackAt = -1;
    rdAt = '0;
    cpuReqB = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (memEnB) enCnt++;
      if (cpuAckB && ackAt < 0) begin
        ackAt = cyc;
        rdAt = rdataB;
      end
      @(posedge clk);
      #1;
      if (ackAt >= 0) cpuReqB = 1'b0;
    end
    checkOutput("s6 ack cycle", 64'(ackAt - s), 64'd2);
    checkOutput("s6 mem_en cycles", 64'(enCnt), 64'd1);
    checkOutput("s6 rdata", rdAt, 64'h5555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
